// File: rtl/tx_word.sv
// tx_word: 8N1 UART transmitter sending a word as uppercase hex ASCII followed by CR LF
module tx_word #(
  parameter int RESOLUTION = 16
) (
  output logic                  tx,
  input  logic [RESOLUTION-1:0] data,
  input  logic                  clk,
  input  logic                  enable,
  input  logic                  reset,
  output logic                  busy
);
  localparam int NIBBLES = RESOLUTION / 4;
  localparam int CW = $clog2(NIBBLES + 2);
  localparam logic [CW-1:0] CR_IDX = CW'(NIBBLES);
  localparam logic [CW-1:0] LF_IDX = CW'(NIBBLES + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [RESOLUTION-1:0] word;
  logic [CW-1:0] idx;
  logic [2:0] bit_cnt;
  logic [3:0] nib;
  logic [7:0] hex;
  logic [7:0] char_cur;
  // the latched word shifts left per character, so its top nibble is always the one being sent
  always_comb begin
    nib = word[RESOLUTION-1 -: 4];
    hex = nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    char_cur = idx == LF_IDX ? 8'h0A : idx == CR_IDX ? 8'h0D : hex;
  end
  // framing state machine with registered tx and busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      word    <= '0;
      idx     <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          word  <= data;
          idx   <= '0;
          state <= START;
          tx    <= 1'b0;
          busy  <= 1'b1;
        end
        START: begin
          state   <= DATA;
          tx      <= char_cur[0];
          bit_cnt <= '0;
        end
        DATA: if (bit_cnt == 3'd7) begin
          state <= STOP;
          tx    <= 1'b1;
        end else begin
          tx      <= char_cur[bit_cnt + 3'd1];
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: if (idx != LF_IDX) begin
          idx   <= idx + 1'b1;
          word  <= word << 4;
          state <= START;
          tx    <= 1'b0;
        end else if (enable) begin
          word  <= data;
          idx   <= '0;
          state <= START;
          tx    <= 1'b0;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tx_word.sv
// tb_tx_word: scoreboard bench decoding the serial lines of a 16-bit and an 8-bit transmitter
module tb_tx_word;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] data16 = '0;
  logic [7:0] data8 = '0;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  logic tx0, tx1, busy0, busy1;
  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic act[2] = '{1'b0, 1'b0};
  int bc[2];
  logic [7:0] sh[2];

  tx_word #(.RESOLUTION(16)) dut16 (.tx(tx0), .data(data16), .clk(clk), .enable(en0), .reset(reset), .busy(busy0));
  tx_word #(.RESOLUTION(8))  dut8  (.tx(tx1), .data(data8),  .clk(clk), .enable(en1), .reset(reset), .busy(busy1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push0(input logic [47:0] s);
    for (int i = 5; i >= 0; i--) q0.push_back(s[i*8 +: 8]);
  endtask

  task automatic push1(input logic [31:0] s);
    for (int i = 3; i >= 0; i--) q1.push_back(s[i*8 +: 8]);
  endtask

  task automatic measure(input int k, input int drop, input int chg, output int n);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (!(k == 0 ? busy0 : busy1)) break;
      n++;
      if (n == chg) begin
        data16 = 16'h0009;
        push0(48'h30_30_30_39_0D_0A);
      end
      if (n == drop) begin
        if (k == 0) en0 = 1'b0;
        else en1 = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    logic t;
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      t = k == 0 ? tx0 : tx1;
      if (reset) act[k] = 1'b0;
      else if (!act[k]) begin
        if (t === 1'b0) begin
          act[k] = 1'b1;
          bc[k] = 0;
        end
      end else begin
        bc[k]++;
        if (bc[k] <= 8) sh[k] = {t, sh[k][7:1]};
        else begin
          act[k] = 1'b0;
          chk($sformatf("stop_bit%0d", k), int'(t === 1'b1), 1);
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_char%0d: got %0h expected none", k, sh[k]);
          end else begin
            e = k == 0 ? q0.pop_front() : q1.pop_front();
            chk($sformatf("char%0d", k), int'(sh[k]), int'(e));
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx0 === 1'b1), 1);
    chk("reset_busy", int'(busy0 === 1'b0), 1);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_tx", int'(tx0 === 1'b1 && tx1 === 1'b1), 1);
      chk("idle_busy", int'(busy0 === 1'b0), 1);
    end
    data16 = 16'h1A2F;
    en0 = 1'b1;
    push0(48'h31_41_32_46_0D_0A);
    measure(0, 1, 0, n);
    chk("single_len", n, 60);
    chk("single_idle_tx", int'(tx0 === 1'b1), 1);
    repeat (3) @(negedge clk);
    data16 = 16'hFFFF;
    en0 = 1'b1;
    push0(48'h46_46_46_46_0D_0A);
    measure(0, 61, 25, n);
    chk("stream_len", n, 120);
    chk("stream_idle_tx", int'(tx0 === 1'b1), 1);
    repeat (3) @(negedge clk);
    data16 = 16'hBEEF;
    en0 = 1'b1;
    push0(48'h42_45_45_46_0D_0A);
    measure(0, 5, 0, n);
    chk("early_len", n, 60);
    chk("early_idle_tx", int'(tx0 === 1'b1), 1);
    repeat (3) @(negedge clk);
    data16 = 16'h1234;
    en0 = 1'b1;
    push0(48'h31_32_33_34_0D_0A);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_tx", int'(tx0 === 1'b1), 1);
    chk("async_rst_busy", int'(busy0 === 1'b0), 1);
    q0.delete();
    repeat (2) @(negedge clk);
    chk("hold_rst_tx", int'(tx0 === 1'b1), 1);
    data16 = 16'h7E01;
    push0(48'h37_45_30_31_0D_0A);
    reset = 1'b0;
    measure(0, 1, 0, n);
    chk("post_rst_len", n, 60);
    repeat (3) @(negedge clk);
    data8 = 8'hC3;
    en1 = 1'b1;
    push1(32'h43_33_0D_0A);
    measure(1, 1, 0, n);
    chk("res8_len", n, 40);
    chk("res8_idle_tx", int'(tx1 === 1'b1), 1);
    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tx_word.md
Name: tx_word

Overview:
- UART transmitter for one wide word; sends it as uppercase ASCII hex text followed by CR LF.
- Sits between the correlator/counter result register and the host serial line.
- Streams the whole packed counter vector, one word per integration period, while enabled.
- The clock is the bit-rate clock: one serial bit per clock cycle.

Parameters:
- RESOLUTION, 16: width of the data word in bits; must be a multiple of 4. NIBBLES = RESOLUTION/4 hex characters per word.

Ports:
- clk  input  1  bit-rate clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- tx  output  1  serial line; idle high; 8N1 framing, LSB first.
- data  input  RESOLUTION  word to transmit; sampled only at word start.
- enable  input  1  streaming enable; level-sensitive.
- busy  output  1  high while a word (including CR LF) is in flight.
- Positional order for instantiation: tx, data, clk, enable, reset, busy.

Behaviour:
- Reset is asynchronous and active-high. It forces tx=1 and busy=0, clears all counters and the shift register, and returns to IDLE immediately, even mid-character.
- States:
  - IDLE: tx=1, busy=0.
  - START: one cycle, tx=0.
  - DATA: 8 cycles, bits 0..7 of the current character, LSB first.
  - STOP: one cycle, tx=1.
- Every character occupies exactly 10 clock cycles.
- Word start: on a posedge in IDLE with enable=1:
  - latch data into an internal register;
  - set the character index to 0;
  - enter START. tx is registered and goes low on that same edge; busy goes high on that edge.
- Character sequence per word:
  - NIBBLES hex characters, most significant nibble first (data[RESOLUTION-1 -: 4] first).
  - Then 0x0D (CR), then 0x0A (LF).
- Hex encoding:
  - nibble 0–9 → 0x30–0x39;
  - nibble 10–15 → 0x41–0x46 ('A'–'F', uppercase).
- Consecutive characters are back-to-back: the next START follows STOP with no idle cycle.
- Word length: (NIBBLES+2)*10 cycles. RESOLUTION=16 gives 60 cycles.
- End of word (the edge ending the LF stop bit):
  - enable=1: re-latch data and begin a new START on that same edge; no idle gap between words.
  - enable=0: go to IDLE, tx=1, busy=0.
- enable deasserted mid-word: the current word, including CR LF, completes; no truncation.
- enable re-asserted mid-word: no effect until the word ends.
- data changes mid-word are ignored; the latched copy is transmitted.
- No parity, one stop bit.
- Internal counters must handle RESOLUTION up to at least 2048 (≥512 characters) without overflow. Size the character index as clog2(NIBBLES+2).
- No X on tx after reset deassertion.

Test Plan:
1. Reset: assert reset with enable=0 → tx=1, busy=0. Hold 20 cycles after release → tx remains 1.
2. Single word, RESOLUTION=16, data=16'h1A2F, enable pulsed high for 1 cycle:
   - decoded characters are 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A;
   - exactly 60 cycles of busy=1, then tx=1 idle.
3. Streaming: enable held high, data=16'hFFFF then changed to 16'h0009 at cycle 25:
   - first word is "FFFF\r\n";
   - second word starts with no gap at cycle 60 and is "0009\r\n".
4. Early disable: data=16'hBEEF, enable dropped at cycle 5 → full "BEEF\r\n" is still sent (60 cycles), then idle.
5. Reset mid-word: assert reset during the DATA bits of the 2nd character → tx=1 and busy=0 asynchronously, before the next edge. After release with enable=1, the next word starts cleanly from its first nibble.
6. Parameter check, RESOLUTION=8, data=8'hC3 → "C3\r\n" = 0x43, 0x33, 0x0D, 0x0A in 40 cycles.
